// File: rtl/pipe_pkg.sv
// Shared constants for pipeline-stage registers: default payload width,
// the PC reset vector and the occupancy encoding reported on level.
package pipe_pkg;

    localparam int          DEFAULT_WIDTH  = 32;
    localparam logic [31:0] PC_RESET_VALUE = 32'h8002_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } level_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: payload plus valid bit, with a
// load enable and a clear that drops the entry but leaves the payload intact.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values;
    // the payload is reset too because RESET_VALUE is architecturally visible (PC).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (clear) begin
            // NOTE: clear beats load so a squashed entry never lands, and data holds.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional skid slot that makes in_ready a pure register output.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       level
);

    logic             accept;
    logic             consume;
    logic             main_valid;
    logic             main_load;
    logic             main_clear;
    logic [WIDTH-1:0] main_din;

    assign accept    = in_valid & in_ready;
    assign consume   = main_valid & out_ready;
    assign out_valid = main_valid;

    pipe_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clock     (clock),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_din),
        .valid     (main_valid),
        .data      (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic             skid_valid;
            logic             skid_load;
            logic             skid_clear;
            logic [WIDTH-1:0] skid_data;
            logic             main_free;

            // Main can take a new entry when it is empty or its head leaves now.
            assign main_free  = ~main_valid | consume;
            assign in_ready   = ~skid_valid;

            // The skid entry is older than anything arriving, so it drains first.
            assign main_load  = main_free & (skid_valid | accept);
            assign main_din   = skid_valid ? skid_data : in_data;
            assign main_clear = flush | (main_free & ~skid_valid & ~accept);

            assign skid_load  = ~main_free & accept;
            assign skid_clear = flush | (main_free & skid_valid);

            pipe_slot #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid (
                .clock     (clock),
                .reset     (reset),
                .clear     (skid_clear),
                .load      (skid_load),
                .load_data (in_data),
                .valid     (skid_valid),
                .data      (skid_data)
            );

            always_comb begin
                level = EMPTY;
                case ({main_valid, skid_valid})
                    2'b11:   level = FULL;
                    2'b00:   level = EMPTY;
                    default: level = ONE;
                endcase
            end
        end else begin : g_single
            assign in_ready   = ~main_valid | out_ready;
            assign main_load  = accept;
            assign main_din   = in_data;
            assign main_clear = flush | (consume & ~accept);
            assign level      = main_valid ? ONE : EMPTY;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Checks a single-entry and a skid-buffered stage against a FIFO model,
// plus directed reset, stream, backpressure, flush and accept+consume cases.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                flush = 1'b0;
    logic [1:0]          iv    = '0;
    logic [1:0]          ordy  = '0;
    logic [1:0][W-1:0]   idat  = '0;
    logic [1:0]          irdy;
    logic [1:0]          ov;
    logic [1:0][W-1:0]   od;
    logic [1:0][1:0]     lvl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(
        .WIDTH (W),
        .SKID  (1'b0)
    ) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (iv[0]),
        .in_data   (idat[0]),
        .in_ready  (irdy[0]),
        .out_valid (ov[0]),
        .out_data  (od[0]),
        .out_ready (ordy[0]),
        .level     (lvl[0])
    );

    pipe_stage_reg #(
        .WIDTH       (W),
        .RESET_VALUE (PC_RESET_VALUE),
        .SKID        (1'b1)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (iv[1]),
        .in_data   (idat[1]),
        .in_ready  (irdy[1]),
        .out_valid (ov[1]),
        .out_data  (od[1]),
        .out_ready (ordy[1]),
        .level     (lvl[1])
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO per instance (capacity 1 without skid,
    // 2 with), plus the last value seen at the head, which out_data must hold.
    logic [W-1:0] m_fifo [2][2];
    int           m_cnt  [2] = '{0, 0};
    logic [W-1:0] m_last [2] = '{'0, PC_RESET_VALUE};

    function automatic logic m_ready(input int k);
        if (k == 0) return (m_cnt[0] == 0) || ordy[0];
        return m_cnt[1] < 2;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt[0]  = 0;
            m_cnt[1]  = 0;
            m_last[0] = '0;
            m_last[1] = PC_RESET_VALUE;
        end else begin
            for (int k = 0; k < 2; k++) begin : step_model
                bit acc;
                bit con;
                acc = iv[k] && m_ready(k);
                con = (m_cnt[k] > 0) && ordy[k];
                if (flush) begin
                    m_cnt[k] = 0;
                end else begin
                    if (con) begin
                        m_fifo[k][0] = m_fifo[k][1];
                        m_cnt[k]--;
                    end
                    if (acc) begin
                        m_fifo[k][m_cnt[k]] = idat[k];
                        m_cnt[k]++;
                    end
                    if (m_cnt[k] > 0) m_last[k] = m_fifo[k][0];
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            string tag;
            tag = (k == 0) ? "skid0" : "skid1";
            check($sformatf("%s out_valid", tag), W'(ov[k]),   W'(m_cnt[k] > 0));
            check($sformatf("%s level", tag),     W'(lvl[k]),  W'(m_cnt[k]));
            check($sformatf("%s in_ready", tag),  W'(irdy[k]), W'(m_ready(k)));
            check($sformatf("%s out_data", tag),  od[k],       m_last[k]);
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        iv      = {v, v};
        idat[0] = d;
        idat[1] = d;
        ordy    = {r, r};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Power-on reset.
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        check("por skid0 out_valid", W'(ov[0]),  '0);
        check("por skid1 level",     W'(lvl[1]), '0);
        check("por skid0 out_data",  od[0],      '0);
        check("por skid1 out_data",  od[1],      32'h8002_0000);
        check("por skid1 in_ready",  W'(irdy[1]), 1);

        // Bubble-free stream through both variants.
        drive(1'b1, 32'h11, 1'b1); step();
        check("stream0 skid0 data", od[0], 32'h11);
        check("stream0 skid1 data", od[1], 32'h11);
        drive(1'b1, 32'h22, 1'b1); step();
        check("stream1 skid1 data",  od[1],      32'h22);
        check("stream1 skid1 level", W'(lvl[1]), 1);
        drive(1'b1, 32'h33, 1'b1); step();
        check("stream2 skid0 data",  od[0],      32'h33);
        check("stream2 skid1 data",  od[1],      32'h33);
        check("stream2 skid0 level", W'(lvl[0]), 1);
        drive(1'b0, '0, 1'b1); step();
        check("drain skid1 out_valid", W'(ov[1]), 0);
        check("drain skid1 hold",      od[1],     32'h33);

        // Backpressure fills the skid slot, then drains in order.
        drive(1'b1, 32'hA, 1'b0); step();
        check("bp A skid1 data", od[1], 32'hA);
        drive(1'b1, 32'hB, 1'b0); step();
        check("bp B skid1 level",    W'(lvl[1]),  2);
        check("bp B skid1 in_ready", W'(irdy[1]), 0);
        drive(1'b1, 32'hC, 1'b0); step();
        check("bp C held level", W'(lvl[1]), 2);
        check("bp C held data",  od[1],      32'hA);
        drive(1'b1, 32'hC, 1'b1); step();
        check("bp out B data",     od[1],       32'hB);
        check("bp out B in_ready", W'(irdy[1]), 1);
        drive(1'b1, 32'hC, 1'b1); step();
        check("bp out C data",  od[1],      32'hC);
        check("bp out C level", W'(lvl[1]), 1);
        drive(1'b0, '0, 1'b1); step();
        check("bp drained level", W'(lvl[1]), 0);

        // Simultaneous accept and consume at level 1.
        drive(1'b1, 32'h1, 1'b0); step();
        drive(1'b1, 32'h2, 1'b1); step();
        check("ac skid0 data",  od[0],      32'h2);
        check("ac skid1 data",  od[1],      32'h2);
        check("ac skid0 level", W'(lvl[0]), 1);
        check("ac skid1 level", W'(lvl[1]), 1);
        drive(1'b0, '0, 1'b1); step();

        // Flush at level 2 discards the concurrent accept; out_data holds.
        drive(1'b1, 32'h66, 1'b0); step();
        drive(1'b1, 32'h77, 1'b0); step();
        check("flush pre level", W'(lvl[1]), 2);
        flush = 1'b1;
        drive(1'b1, 32'h55, 1'b0); step();
        flush = 1'b0;
        check("flush skid1 out_valid", W'(ov[1]),  0);
        check("flush skid1 level",     W'(lvl[1]), 0);
        check("flush skid1 hold",      od[1],      32'h66);
        check("flush skid0 hold",      od[0],      32'h66);
        drive(1'b0, '0, 1'b1); step();
        check("flush no 0x55", od[1], 32'h66);

        // Asynchronous reset in the middle of a full stage.
        drive(1'b1, 32'h91, 1'b0); step();
        drive(1'b1, 32'h92, 1'b0); step();
        check("rst pre level", W'(lvl[1]), 2);
        #2 reset = 1'b0;
        #1;
        check("rst skid1 out_valid", W'(ov[1]),  0);
        check("rst skid1 level",     W'(lvl[1]), 0);
        check("rst skid1 out_data",  od[1],      32'h8002_0000);
        check("rst skid0 out_data",  od[0],      '0);
        drive(1'b0, '0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        step();
        check("rst skid0 in_ready", W'(irdy[0]), 1);
        check("rst skid1 in_ready", W'(irdy[1]), 1);

        // Random traffic with occasional flushes, checked by the model every cycle.
        for (int i = 0; i < 10000; i++) begin
            iv      = 2'($urandom);
            ordy    = 2'($urandom);
            idat[0] = $urandom;
            idat[1] = $urandom;
            flush   = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generalises the plain clocked register with four additions: a configurable reset value, a valid/ready handshake, an optional 2-entry skid buffer that breaks the ready path, and a synchronous flush.
- Sits between any two pipeline stages; backpressure from the downstream stage stalls the upstream one.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out_data on reset. The PC instance uses 32'h80020000.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has data.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data holds a live entry.
- out_data  out  WIDTH  head payload.
- out_ready  in  1  downstream consumes the head this cycle.
- level  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - Both are evaluated on the rising clock edge.
- Reset (reset==0, asynchronous, any time including mid-transfer):
  - out_data=RESET_VALUE, out_valid=0, skid slot empty, level=0.
  - In-flight entries are lost.
  - in_ready=1 from the first cycle after deassertion.
- Flush (synchronous; highest priority after reset):
  - Next state: out_valid=0, skid empty, level=0.
  - Any Accept in the flush cycle is discarded.
  - out_data holds its previous value; it is not reset.
  - A Consume in the flush cycle is still a valid transfer downstream.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On Accept: out_data<=in_data, out_valid<=1.
  - On Consume without Accept: out_valid<=0.
  - Latency 1 cycle; full throughput with a 1-cycle bubble-free stream.
- SKID=1:
  - Storage: main slot (drives out_*) and skid slot.
  - in_ready = ~skid_valid, registered; no combinational path from out_ready.
  - Main empty, or Consume: main loads the skid slot if it is full, else in_data on Accept; otherwise main becomes empty.
  - Main full, no Consume, Accept: entry goes to the skid slot.
  - Order is strictly FIFO. Latency 1 cycle; throughput 1 per cycle when out_ready=1.
- Hold: with no load, out_data and the skid data keep their values (bit-exact).
- level equals the number of valid slots after the edge and is updated on the same edge.
- Simultaneous Accept and Consume at level=1: level stays 1 and the main slot takes the new data.
- At level=2, in_ready=0 and in_valid is ignored.
- Arithmetic: none on the payload; level is a 2-bit unsigned value that never wraps.

Decomposition:
- Shared package pipe_pkg holds:
  - constant PC_RESET_VALUE = 32'h80020000;
  - the default WIDTH constant;
  - the level encoding constants (EMPTY=0, ONE=1, FULL=2).
- One natural sub-module, pipe_slot: a single WIDTH-bit storage slot with valid bit, load enable, clear, and async active-low reset to RESET_VALUE. The top instantiates it once (SKID=0) or twice (SKID=1) and contains only the steering and handshake logic.

Test Plan:
1. Reset: hold reset=0 mid-stream with level=2, then release → out_valid=0, level=0, out_data=32'h80020000 (PC instance), in_ready=1 one cycle later.
2. Stream: out_ready=1; send 8'h11, 8'h22, 8'h33 on consecutive cycles → out_data shows 11, 22, 33 on cycles 1, 2, 3; level stays 1.
3. Backpressure (SKID=1): out_ready=0; send A=0xA, B=0xB, C=0xC → level=2 after B; in_ready=0; C is held by upstream. Raise out_ready → outputs A, B, C in order with no loss or duplication.
4. Flush: at level=2, assert flush with in_valid=1 and data 0x55 → next cycle out_valid=0, level=0, 0x55 never appears; out_data retains its last value.
5. Simultaneous Accept+Consume at level=1 (SKID=0 and SKID=1): head 0x1, input 0x2 → next cycle out_data=0x2, level=1.
6. Random in_valid/out_ready for 10k cycles against a FIFO scoreboard, both SKID values → zero mismatches; level never exceeds 2 (1 when SKID=0).
